// File: rtl/warp_instr_buffer.sv
// Per-warp show-ahead instruction FIFOs between fetch and issue.
// One shared write port, one shared read port, per-warp flush.
package warp_pkg;
   localparam int FIFO_DEPTH = 8;
endpackage

module warp_instr_buffer #(
   parameter int NUM_WARPS  = 4,
   parameter int FIFO_DEPTH = warp_pkg::FIFO_DEPTH,
   parameter int DATA_WIDTH = 32,
   parameter int AF_THRESH  = FIFO_DEPTH - 2,
   localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
   localparam int PW = $clog2(FIFO_DEPTH),
   localparam int CW = PW + 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            push,
   input  logic [WW-1:0]                   push_warp,
   input  logic [DATA_WIDTH-1:0]           data_in,
   input  logic                            pop,
   input  logic [WW-1:0]                   pop_warp,
   input  logic [NUM_WARPS-1:0]            flush,
   output logic [NUM_WARPS*DATA_WIDTH-1:0] head_data,
   output logic [NUM_WARPS-1:0]            head_valid,
   output logic [NUM_WARPS-1:0]            full,
   output logic [NUM_WARPS-1:0]            almost_full,
   output logic [NUM_WARPS-1:0]            empty,
   output logic [NUM_WARPS*CW-1:0]         count,
   output logic                            overflow_err,
   output logic                            underflow_err,
   input  logic                            err_clr
);

   logic [DATA_WIDTH-1:0] mem_q [NUM_WARPS][FIFO_DEPTH];
   logic [PW-1:0]         wr_q  [NUM_WARPS];
   logic [PW-1:0]         wr_d  [NUM_WARPS];
   logic [PW-1:0]         rd_q  [NUM_WARPS];
   logic [PW-1:0]         rd_d  [NUM_WARPS];
   logic [CW-1:0]         cnt_q [NUM_WARPS];
   logic [CW-1:0]         cnt_d [NUM_WARPS];
   logic [NUM_WARPS-1:0]  push_acc;
   logic [NUM_WARPS-1:0]  pop_acc;
   logic [31:0]           push_wx;
   logic [31:0]           pop_wx;
   logic                  push_ok;
   logic                  pop_ok;
   logic                  push_blk;
   logic                  pop_blk;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;

   always_comb begin
      push_wx  = 32'(push_warp);
      pop_wx   = 32'(pop_warp);
      push_ok  = push_wx < NUM_WARPS;
      pop_ok   = pop_wx < NUM_WARPS;
      push_blk = push_ok && flush[push_warp];
      pop_blk  = pop_ok && flush[pop_warp];
      push_acc = '0;
      pop_acc  = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         pop_acc[w] = pop && pop_ok && (pop_warp == WW'(w)) &&
                      !flush[w] && (cnt_q[w] != '0);
         // A full warp still takes a write when its head leaves this cycle.
         push_acc[w] = push && push_ok && (push_warp == WW'(w)) &&
                       !flush[w] &&
                       ((cnt_q[w] != CW'(FIFO_DEPTH)) || pop_acc[w]);
         wr_d[w]  = wr_q[w];
         rd_d[w]  = rd_q[w];
         cnt_d[w] = cnt_q[w];
         if (flush[w]) begin
            wr_d[w]  = '0;
            rd_d[w]  = '0;
            cnt_d[w] = '0;
         end else begin
            if (push_acc[w]) wr_d[w] = wr_q[w] + PW'(1);
            if (pop_acc[w])  rd_d[w] = rd_q[w] + PW'(1);
            case ({push_acc[w], pop_acc[w]})
               2'b10:   cnt_d[w] = cnt_q[w] + CW'(1);
               2'b01:   cnt_d[w] = cnt_q[w] - CW'(1);
               default: cnt_d[w] = cnt_q[w];
            endcase
         end
      end
      ovf_d = ovf_q;
      udf_d = udf_q;
      if (err_clr) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
      if (push && !push_blk && (push_acc == '0)) ovf_d = 1'b1;
      if (pop && !pop_blk && (pop_acc == '0))    udf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            wr_q[w]  <= '0;
            rd_q[w]  <= '0;
            cnt_q[w] <= '0;
         end
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            wr_q[w]  <= wr_d[w];
            rd_q[w]  <= rd_d[w];
            cnt_q[w] <= cnt_d[w];
         end
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
         if (push_acc[w]) mem_q[w][wr_q[w]] <= data_in;
      end
   end

   always_comb begin
      head_data   = '0;
      head_valid  = '0;
      full        = '0;
      almost_full = '0;
      empty       = '0;
      count       = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         count[w*CW +: CW] = cnt_q[w];
         empty[w]          = cnt_q[w] == '0;
         head_valid[w]     = cnt_q[w] != '0;
         full[w]           = cnt_q[w] == CW'(FIFO_DEPTH);
         almost_full[w]    = cnt_q[w] >= CW'(AF_THRESH);
         if (cnt_q[w] != '0) begin
            head_data[w*DATA_WIDTH +: DATA_WIDTH] = mem_q[w][rd_q[w]];
         end
      end
   end

   assign overflow_err  = ovf_q;
   assign underflow_err = udf_q;

endmodule

// File: tb/tb_warp_instr_buffer.sv
// Randomized bench for warp_instr_buffer against a queue-based model.
// Directed scenarios first, then random traffic.
module tb_warp_instr_buffer;

   localparam int NW = 4;
   localparam int DP = 8;
   localparam int DW = 32;
   localparam int AF = DP - 2;
   localparam int CW = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            push = 1'b0;
   logic [1:0]      push_warp = '0;
   logic [DW-1:0]   data_in = '0;
   logic            pop = 1'b0;
   logic [1:0]      pop_warp = '0;
   logic [NW-1:0]   flush = '0;
   logic [NW*DW-1:0] head_data;
   logic [NW-1:0]   head_valid;
   logic [NW-1:0]   full;
   logic [NW-1:0]   almost_full;
   logic [NW-1:0]   empty;
   logic [NW*CW-1:0] count;
   logic            overflow_err;
   logic            underflow_err;
   logic            err_clr = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   logic [DW-1:0] mq [NW][$];
   bit ovf_m = 0;
   bit udf_m = 0;

   warp_instr_buffer #(
      .NUM_WARPS (NW),
      .FIFO_DEPTH(DP),
      .DATA_WIDTH(DW),
      .AF_THRESH (AF)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .push         (push),
      .push_warp    (push_warp),
      .data_in      (data_in),
      .pop          (pop),
      .pop_warp     (pop_warp),
      .flush        (flush),
      .head_data    (head_data),
      .head_valid   (head_valid),
      .full         (full),
      .almost_full  (almost_full),
      .empty        (empty),
      .count        (count),
      .overflow_err (overflow_err),
      .underflow_err(underflow_err),
      .err_clr      (err_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      for (int w = 0; w < NW; w++) begin
         int sz = mq[w].size();
         logic [DW-1:0] hd = (sz > 0) ? mq[w][0] : '0;
         check($sformatf("count%0d", w), count[w*CW +: CW], sz);
         check($sformatf("empty%0d", w), empty[w], sz == 0);
         check($sformatf("hvalid%0d", w), head_valid[w], sz != 0);
         check($sformatf("full%0d", w), full[w], sz == DP);
         check($sformatf("afull%0d", w), almost_full[w], sz >= AF);
         check($sformatf("head%0d", w), head_data[w*DW +: DW], hd);
      end
      check("ovf", overflow_err, ovf_m);
      check("udf", underflow_err, udf_m);
   endtask

   task automatic cyc(input bit pu, input int pw, input logic [DW-1:0] d,
                      input bit po, input int ow, input logic [NW-1:0] fl,
                      input bit clr);
      bit pop_a, push_a, o_set, u_set;
      @(negedge clk);
      push      = pu;
      push_warp = 2'(pw);
      data_in   = d;
      pop       = po;
      pop_warp  = 2'(ow);
      flush     = fl;
      err_clr   = clr;
      pop_a  = po && !fl[ow] && (mq[ow].size() > 0);
      push_a = pu && !fl[pw] &&
               ((mq[pw].size() < DP) || (pop_a && ow == pw));
      o_set  = pu && !fl[pw] && !push_a;
      u_set  = po && !fl[ow] && !pop_a;
      if (pop_a)  void'(mq[ow].pop_front());
      if (push_a) mq[pw].push_back(d);
      for (int w = 0; w < NW; w++) if (fl[w]) mq[w].delete();
      ovf_m = o_set ? 1'b1 : (clr ? 1'b0 : ovf_m);
      udf_m = u_set ? 1'b1 : (clr ? 1'b0 : udf_m);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle();
      cyc(0, 0, '0, 0, 0, '0, 0);
   endtask

   initial begin
      #12;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // 1: basic show-ahead on warp 2
      cyc(1, 2, 32'h11, 0, 0, '0, 0);
      cyc(1, 2, 32'h22, 0, 0, '0, 0);
      check("t1_hv", head_valid, 4'b0100);
      check("t1_hd", head_data[2*DW +: DW], 32'h11);
      cyc(0, 0, '0, 1, 2, '0, 0);
      check("t1_hd2", head_data[2*DW +: DW], 32'h22);
      check("t1_cnt", count[2*CW +: CW], 1);

      // 2: fill warp 0, then overflow
      for (int i = 0; i < DP; i++) begin
         cyc(1, 0, 32'h100 + i, 0, 0, '0, 0);
         check($sformatf("t2_af%0d", i), almost_full[0], (i + 1) >= AF);
      end
      check("t2_full", full[0], 1);
      cyc(1, 0, 32'hDEAD, 0, 0, '0, 0);
      check("t2_ovf", overflow_err, 1);
      check("t2_cnt", count[0 +: CW], DP);
      check("t2_hd", head_data[0 +: DW], 32'h100);
      cyc(0, 0, '0, 0, 0, '0, 1);

      // 3: full pass-through on warp 1
      for (int i = 0; i < DP; i++) cyc(1, 1, 32'h200 + i, 0, 0, '0, 0);
      cyc(1, 1, 32'hAA, 1, 1, '0, 0);
      check("t3_cnt", count[CW +: CW], DP);
      check("t3_hd", head_data[DW +: DW], 32'h201);
      check("t3_ovf", overflow_err, 0);

      // 4: pop empty warp 3 while pushing it
      cyc(1, 3, 32'h5, 1, 3, '0, 0);
      check("t4_udf", underflow_err, 1);
      check("t4_hd", head_data[3*DW +: DW], 32'h5);
      cyc(0, 0, '0, 0, 0, '0, 1);
      check("t4_clr", underflow_err, 0);

      // 5: selective flush, then pointer wrap on warp 0
      cyc(0, 0, '0, 0, 0, 4'hF, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 32'h300 + i, 0, 0, '0, 0);
         cyc(1, 1, 32'h400 + i, 0, 0, '0, 0);
      end
      cyc(1, 0, 32'h3FF, 0, 0, 4'b0001, 0);
      check("t5_cnt0", count[0 +: CW], 0);
      check("t5_cnt1", count[CW +: CW], 3);
      check("t5_ovf", overflow_err, 0);
      cyc(1, 0, 32'h500, 0, 0, '0, 0);
      for (int i = 1; i <= 20; i++) cyc(1, 0, 32'h500 + i, 1, 0, '0, 0);
      check("t5_hd", head_data[0 +: DW], 32'h514);

      // 6: asynchronous reset mid-operation
      for (int i = 0; i < 4; i++) cyc(1, 2, 32'h600 + i, 0, 0, '0, 0);
      @(negedge clk);
      push = 1'b0;
      pop  = 1'b0;
      #2;
      rst_n = 1'b0;
      for (int w = 0; w < NW; w++) mq[w].delete();
      ovf_m = 0;
      udf_m = 0;
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      idle();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         logic [NW-1:0] fl;
         fl = '0;
         for (int w = 0; w < NW; w++) fl[w] = ($urandom_range(0, 24) == 0);
         cyc($urandom_range(0, 9) < 6, $urandom_range(0, NW - 1), $urandom,
             $urandom_range(0, 9) < 4, $urandom_range(0, NW - 1), fl,
             $urandom_range(0, 19) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
